// File: rtl/spike_readout_arbiter_if.sv
// system_if: clock/reset bundle shared by the network blocks.
//   clk     - system clock, all state on the rising edge
//   reset_n - asynchronous active-low reset (release synchronised upstream)
//   nn      - consumer modport for network blocks (clk, reset_n as inputs)
interface system_if;
  logic clk;
  logic reset_n;

  modport nn (input clk, input reset_n);
endinterface

// File: rtl/spike_readout_arbiter.sv
// spike_readout_arbiter: captures per-column spike events, arbitrates them
// round-robin into an output FIFO and presents them as a valid/ready stream.
// Collisions on a still-pending column and spikes against a full FIFO are
// counted in a saturating drop counter.
//
// Optional feature macro: SPIKE_READOUT_TIMESTAMP_EN
//   defined   - free-running timestamp, per-column latches, timestamp in FIFO
//   undefined - FIFO carries column only, out_timestamp tied to 0
//
// Ports:
//   sys_if        - system_if.nn, provides clk and async active-low reset_n
//   col_spike     - per-column one-cycle spike pulses
//   out_valid     - FIFO head valid
//   out_ready     - monitor accepts head
//   out_column    - column index of head event
//   out_timestamp - capture timestamp of head event
//   fifo_level    - FIFO occupancy
//   drop_count    - saturating count of lost events
module spike_readout_arbiter #(
  parameter int unsigned NUM_COLS   = 1,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TS_WIDTH   = 16,
  parameter int unsigned DROP_W     = 8,
  localparam int unsigned COL_W     = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1,
  localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  system_if.nn                sys_if,
  input  logic [NUM_COLS-1:0] col_spike,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [COL_W-1:0]    out_column,
  output logic [TS_WIDTH-1:0] out_timestamp,
  output logic [LVL_W-1:0]    fifo_level,
  output logic [DROP_W-1:0]   drop_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned DN_W  = $clog2(NUM_COLS + 1);
  localparam int unsigned SUM_W = DROP_W + DN_W;
  localparam logic [COL_W-1:0] LAST_RST = COL_W'(NUM_COLS - 1);

  logic [NUM_COLS-1:0] pending_q, pending_d;
  logic [COL_W-1:0]    last_grant_q, last_grant_d;
  logic [DROP_W-1:0]   drop_d;
  logic [DN_W-1:0]     drop_n;
  logic [SUM_W-1:0]    drop_sum;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_pop, level_d;
  logic                out_valid_d;
  logic [COL_W-1:0]    head_col_d;
  logic [COL_W-1:0]    mem_col [FIFO_DEPTH];
  logic                grant_valid, push, pop;
  logic [COL_W-1:0]    grant_col;
`ifdef SPIKE_READOUT_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic [TS_WIDTH-1:0] ts_latch_q [NUM_COLS];
  logic [TS_WIDTH-1:0] ts_latch_d [NUM_COLS];
  logic [TS_WIDTH-1:0] mem_ts [FIFO_DEPTH];
  logic [TS_WIDTH-1:0] head_ts_d;
`endif

  // Round-robin grant over registered pending, starting after last_grant;
  // gated by the registered level only (no credit for a same-cycle pop).
  always_comb begin
    int unsigned idx;
    grant_valid = 1'b0;
    grant_col   = '0;
    idx         = 0;
    for (int unsigned i = 1; i <= NUM_COLS; i++) begin
      idx = 32'(last_grant_q) + i;
      if (idx >= NUM_COLS) idx = idx - NUM_COLS;
      if (!grant_valid && pending_q[COL_W'(idx)] &&
          (fifo_level < LVL_W'(FIFO_DEPTH))) begin
        grant_valid = 1'b1;
        grant_col   = COL_W'(idx);
      end
    end
  end

  // Capture and collision: the granted column is cleared first, so a spike
  // on it re-arms pending with the fresh timestamp instead of dropping.
  always_comb begin
    pending_d    = pending_q;
    last_grant_d = grant_valid ? grant_col : last_grant_q;
    drop_n       = '0;
`ifdef SPIKE_READOUT_TIMESTAMP_EN
    ts_d       = ts_q + TS_WIDTH'(1);
    ts_latch_d = ts_latch_q;
`endif
    if (grant_valid) pending_d[grant_col] = 1'b0;
    for (int unsigned c = 0; c < NUM_COLS; c++) begin
      if (col_spike[COL_W'(c)]) begin
        if (pending_d[COL_W'(c)]) begin
          drop_n = drop_n + DN_W'(1);
        end else begin
          pending_d[COL_W'(c)] = 1'b1;
`ifdef SPIKE_READOUT_TIMESTAMP_EN
          ts_latch_d[COL_W'(c)] = ts_q;
`endif
        end
      end
    end
    drop_sum = SUM_W'(drop_count) + SUM_W'(drop_n);
    if (drop_sum > SUM_W'({DROP_W{1'b1}})) drop_d = '1;
    else                                    drop_d = drop_sum[DROP_W-1:0];
  end

  // FIFO bookkeeping; head registers are loaded with the next-cycle head,
  // bypassing the memory when the pushed entry becomes the head.
  always_comb begin
    push        = grant_valid;
    pop         = out_valid && out_ready;
    wr_ptr_d    = wr_ptr_q + PTR_W'(push);
    rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
    level_pop   = fifo_level - LVL_W'(pop);
    level_d     = level_pop + LVL_W'(push);
    out_valid_d = (level_d != '0);
    head_col_d  = out_column;
`ifdef SPIKE_READOUT_TIMESTAMP_EN
    head_ts_d   = out_timestamp;
`endif
    if (push && (level_pop == '0)) begin
      head_col_d = grant_col;
`ifdef SPIKE_READOUT_TIMESTAMP_EN
      head_ts_d  = ts_latch_q[grant_col];
`endif
    end else if (level_d != '0) begin
      head_col_d = mem_col[rd_ptr_d];
`ifdef SPIKE_READOUT_TIMESTAMP_EN
      head_ts_d  = mem_ts[rd_ptr_d];
`endif
    end
  end

  // FIFO storage, written on push only.
  always_ff @(posedge sys_if.clk) begin
    if (push) begin
      mem_col[wr_ptr_q] <= grant_col;
`ifdef SPIKE_READOUT_TIMESTAMP_EN
      mem_ts[wr_ptr_q]  <= ts_latch_q[grant_col];
`endif
    end
  end

  // State registers.
  always_ff @(posedge sys_if.clk or negedge sys_if.reset_n) begin
    if (!sys_if.reset_n) begin
      pending_q    <= '0;
      last_grant_q <= LAST_RST;
      drop_count   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_level   <= '0;
      out_valid    <= 1'b0;
      out_column   <= '0;
`ifdef SPIKE_READOUT_TIMESTAMP_EN
      ts_q          <= '0;
      ts_latch_q    <= '{default: '0};
      out_timestamp <= '0;
`endif
    end else begin
      pending_q    <= pending_d;
      last_grant_q <= last_grant_d;
      drop_count   <= drop_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_level   <= level_d;
      out_valid    <= out_valid_d;
      out_column   <= head_col_d;
`ifdef SPIKE_READOUT_TIMESTAMP_EN
      ts_q          <= ts_d;
      ts_latch_q    <= ts_latch_d;
      out_timestamp <= head_ts_d;
`endif
    end
  end

`ifndef SPIKE_READOUT_TIMESTAMP_EN
  assign out_timestamp = '0;
`endif

endmodule

// File: tb/tb_spike_readout_arbiter.sv
`timescale 1ns/1ps
module tb_spike_readout_arbiter;

  localparam int NC     = 4;
  localparam int DEPTH  = 8;
  localparam int TSW    = 16;
  localparam int DW     = 8;
  localparam int DMAX   = (1 << DW) - 1;
  localparam int TSMASK = (1 << TSW) - 1;
`ifdef SPIKE_READOUT_TIMESTAMP_EN
  localparam int TS_EN = 1;
`else
  localparam int TS_EN = 0;
`endif

  system_if sys_if_i ();

  logic [NC-1:0]  col_spike;
  logic           out_ready, out_valid;
  logic [1:0]     out_column;
  logic [TSW-1:0] out_timestamp;
  logic [3:0]     fifo_level;
  logic [DW-1:0]  drop_count;

  // Second instance: one column, tiny timestamp/drop widths, depth 2.
  logic [0:0] col_spike2, out_column2;
  logic       out_ready2, out_valid2;
  logic [3:0] out_timestamp2;
  logic [1:0] fifo_level2, drop_count2;

  spike_readout_arbiter #(.NUM_COLS(NC), .FIFO_DEPTH(DEPTH), .TS_WIDTH(TSW), .DROP_W(DW)) dut (
    .sys_if(sys_if_i), .col_spike(col_spike), .out_valid(out_valid), .out_ready(out_ready),
    .out_column(out_column), .out_timestamp(out_timestamp), .fifo_level(fifo_level),
    .drop_count(drop_count));

  spike_readout_arbiter #(.NUM_COLS(1), .FIFO_DEPTH(2), .TS_WIDTH(4), .DROP_W(2)) dut2 (
    .sys_if(sys_if_i), .col_spike(col_spike2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_column(out_column2), .out_timestamp(out_timestamp2), .fifo_level(fifo_level2),
    .drop_count(drop_count2));

  initial sys_if_i.clk = 1'b0;
  always #5 sys_if_i.clk = ~sys_if_i.clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // Reference model: pending flags, a queue as the FIFO, integer counters.
  typedef struct { int col; int ts; } ev_t;
  ev_t m_q[$];
  bit  m_pend[NC];
  int  m_pts[NC];
  int  m_last, m_ts, m_drop;

  function automatic void model_reset();
    m_q.delete();
    for (int i = 0; i < NC; i++) begin m_pend[i] = 1'b0; m_pts[i] = 0; end
    m_last = NC - 1;
    m_ts   = 0;
    m_drop = 0;
  endfunction

  function automatic void model_step(input logic [NC-1:0] sp, input bit rdy);
    int  g = -1;
    bit  do_pop;
    ev_t e;
    do_pop = (m_q.size() != 0) && rdy;
    if (m_q.size() < DEPTH)
      for (int k = 1; k <= NC; k++)
        if (g < 0 && m_pend[(m_last + k) % NC]) g = (m_last + k) % NC;
    if (do_pop) void'(m_q.pop_front());
    if (g >= 0) begin
      e.col = g; e.ts = m_pts[g];
      m_q.push_back(e);
      m_pend[g] = 1'b0;
      m_last = g;
    end
    for (int c = 0; c < NC; c++)
      if (sp[c]) begin
        if (m_pend[c]) begin
          if (m_drop < DMAX) m_drop++;
        end else begin
          m_pend[c] = 1'b1;
          m_pts[c]  = m_ts;
        end
      end
    m_ts = (m_ts + 1) & TSMASK;
  endfunction

  task automatic model_check(input int t);
    bit ev;
    ev = (m_q.size() != 0);
    check($sformatf("rnd%0d_valid", t), out_valid, ev);
    check($sformatf("rnd%0d_level", t), fifo_level, m_q.size());
    check($sformatf("rnd%0d_drop", t), drop_count, m_drop);
    if (ev) begin
      check($sformatf("rnd%0d_col", t), out_column, m_q[0].col);
      check($sformatf("rnd%0d_ts", t), out_timestamp, TS_EN * m_q[0].ts);
    end
  endtask

  // Enters and leaves at posedge+1; asserts reset mid-cycle for 3 edges.
  task automatic do_reset(input bit chk);
    #3;
    sys_if_i.reset_n = 1'b0;
    #1;
    if (chk) begin
      check("rst_valid", out_valid, 0);
      check("rst_column", out_column, 0);
      check("rst_timestamp", out_timestamp, 0);
      check("rst_level", fifo_level, 0);
      check("rst_drop", drop_count, 0);
    end
    col_spike = '0; out_ready = 1'b0; col_spike2 = '0; out_ready2 = 1'b0;
    repeat (3) @(posedge sys_if_i.clk);
    #1;
    sys_if_i.reset_n = 1'b1;
    model_reset();
  endtask

  // Drive one cycle of inputs, let the edge happen, sample 1ns later.
  task automatic cycle(input logic [NC-1:0] sp, input logic rdy);
    col_spike = sp;
    out_ready = rdy;
    @(posedge sys_if_i.clk);
    model_step(sp, rdy);
    #1;
  endtask

  typedef struct {
    bit       rst;
    logic [3:0] spike;
    bit       rdy;
    bit       valid;
    int       col;
    int       ts;
    int       level;
    int       drop;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input bit rst, input logic [3:0] sp, input bit rdy, input bit v,
                              input int col, input int ts, input int lvl, input int drop);
    vec_t r;
    r.rst = rst; r.spike = sp; r.rdy = rdy; r.valid = v;
    r.col = col; r.ts = ts; r.level = lvl; r.drop = drop;
    tbl.push_back(r);
  endfunction

  initial begin
    ev_t beats[$];
    ev_t b;
    int  p_sp, p_rdy;
    logic [NC-1:0] sp;

    sys_if_i.reset_n = 1'b0;
    col_spike = '0; out_ready = 1'b0; col_spike2 = '0; out_ready2 = 1'b0;
    model_reset();

    // Single event at ts=5, then collision / set-wins / round-robin.
    add(1, 4'b0000, 1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) add(0, 4'b0000, 1, 0, 0, 0, 0, 0);
    add(0, 4'b0100, 1, 0, 0, 0, 0, 0);
    add(0, 4'b0000, 1, 1, 2, 5, 1, 0);
    add(0, 4'b0000, 1, 0, 0, 0, 0, 0);
    add(0, 4'b0000, 1, 0, 0, 0, 0, 0);
    add(0, 4'b0011, 1, 0, 0, 0, 0, 0);
    add(0, 4'b0011, 1, 1, 0, 9, 1, 1);
    add(0, 4'b0000, 1, 1, 1, 9, 1, 1);
    add(0, 4'b0000, 1, 1, 0, 10, 1, 1);
    add(0, 4'b0000, 1, 0, 0, 0, 0, 1);
    // Simultaneous 4'b1011 at ts=10, then 4'b1001 at ts=14.
    add(1, 4'b0000, 1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 9; k++) add(0, 4'b0000, 1, 0, 0, 0, 0, 0);
    add(0, 4'b1011, 1, 0, 0, 0, 0, 0);
    add(0, 4'b0000, 1, 1, 0, 10, 1, 0);
    add(0, 4'b0000, 1, 1, 1, 10, 1, 0);
    add(0, 4'b0000, 1, 1, 3, 10, 1, 0);
    add(0, 4'b1001, 1, 0, 0, 0, 0, 0);
    add(0, 4'b0000, 1, 1, 0, 14, 1, 0);
    add(0, 4'b0000, 1, 1, 3, 14, 1, 0);
    add(0, 4'b0000, 1, 0, 0, 0, 0, 0);

    @(posedge sys_if_i.clk);
    #1;

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset(1'b0);
      cycle(tbl[i].spike, tbl[i].rdy);
      check($sformatf("vec%0d_valid", i), out_valid, tbl[i].valid);
      check($sformatf("vec%0d_level", i), fifo_level, tbl[i].level);
      check($sformatf("vec%0d_drop", i), drop_count, tbl[i].drop);
      if (tbl[i].valid) begin
        check($sformatf("vec%0d_col", i), out_column, tbl[i].col);
        check($sformatf("vec%0d_ts", i), out_timestamp, TS_EN * tbl[i].ts);
      end
    end

    // Timestamp wrap on the 4-bit instance: spike 17 cycles after release.
    do_reset(1'b0);
    out_ready2 = 1'b1;
    for (int k = 0; k < 17; k++) cycle('0, 1'b1);
    col_spike2 = 1'b1;
    cycle('0, 1'b1);
    col_spike2 = 1'b0;
    check("wrap_valid_early", out_valid2, 0);
    cycle('0, 1'b1);
    check("wrap_valid", out_valid2, 1);
    check("wrap_col", out_column2, 0);
    check("wrap_ts", out_timestamp2, TS_EN * 1);
    check("wrap_level", fifo_level2, 1);
    cycle('0, 1'b1);
    check("wrap_valid_after", out_valid2, 0);

    // Backpressure/overflow: column 0 every cycle for 12 cycles, no ready.
    do_reset(1'b0);
    col_spike2 = 1'b1;
    for (int k = 0; k < 12; k++) cycle(4'b0001, 1'b0);
    col_spike2 = 1'b0;
    check("bp_level", fifo_level, 8);
    check("bp_drop", drop_count, 3);
    check("bp_valid", out_valid, 1);
    check("bp_head_ts", out_timestamp, 0);
    check("bp2_level", fifo_level2, 2);
    check("bp2_drop_sat", drop_count2, 3);
    out_ready2 = 1'b1;
    for (int t = 0; t < 40; t++) begin
      if (out_valid) begin
        b.col = int'(out_column);
        b.ts  = int'(out_timestamp);
        beats.push_back(b);
      end
      cycle('0, 1'b1);
    end
    check("bp_beats", beats.size(), 9);
    foreach (beats[i]) begin
      check($sformatf("bp_beat%0d_col", i), beats[i].col, 0);
      check($sformatf("bp_beat%0d_ts", i), beats[i].ts, TS_EN * i);
    end
    check("bp_end_valid", out_valid, 0);

    // Reset mid-drain: three entries queued, then asynchronous reset.
    do_reset(1'b0);
    cycle(4'b0111, 1'b0);
    repeat (3) cycle('0, 1'b0);
    check("md_level", fifo_level, 3);
    check("md_valid", out_valid, 1);
    do_reset(1'b1);
    for (int t = 0; t < 10; t++) begin
      cycle('0, 1'b1);
      check($sformatf("md_nobeat%0d", t), out_valid, 0);
    end

    // Randomized traffic against the reference model.
    do_reset(1'b0);
    p_sp = 20; p_rdy = 50;
    for (int t = 0; t < 3000; t++) begin
      if (t % 500 == 0) begin
        p_sp  = $urandom_range(5, 70);
        p_rdy = $urandom_range(0, 100);
      end
      for (int c = 0; c < NC; c++) sp[c] = ($urandom_range(0, 99) < p_sp);
      cycle(sp, ($urandom_range(0, 99) < p_rdy));
      model_check(t);
    end

    // Reset after traffic: immediate clear, then no stale beat.
    do_reset(1'b1);
    for (int t = 0; t < 8; t++) begin
      cycle('0, 1'b1);
      check($sformatf("post_rst%0d_valid", t), out_valid, 0);
      check($sformatf("post_rst%0d_level", t), fifo_level, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spike_readout_arbiter.md
# spike_readout_arbiter

- Collects spike events from the neuron columns of the network and serialises them into one valid/ready output stream for the external monitor.
- Each column spike is captured with its timestamp and arbitrated round-robin into an output FIFO.
- Collisions and overflow are counted, never silently lost.
- Sits at the network output, opposite the stimulus path that feeds the synapse rows.

## Interface
Parameters:
- NUM_COLS, 1, number of neuron columns (≥1); COL_W = max(1, $clog2(NUM_COLS))
- FIFO_DEPTH, 8, output FIFO entries (power of two, ≥2)
- TS_WIDTH, 16, timestamp counter width
- DROP_W, 8, drop counter width

Ports (clock and reset are delivered by the `system_if.nn` modport, `sys_if`):
- sys_if.clk  input  1  system clock, all state on rising edge
- sys_if.reset_n  input  1  asynchronous, active-low reset
- col_spike  input  NUM_COLS  per-column spike, one-cycle pulse per event
- out_valid  output  1  FIFO head valid
- out_ready  input  1  monitor accepts head
- out_column  output  COL_W  column index of head event
- out_timestamp  output  TS_WIDTH  capture timestamp of head event
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- drop_count  output  DROP_W  saturating count of lost events

## Operation
- ts counter: +1 every cycle, wraps mod 2^TS_WIDTH.
- Capture: col_spike[c]=1 sets pending[c] and latches ts_latch[c]=ts at that edge.
- Collision: col_spike[c]=1 while pending[c] is set and not granted this cycle drops the new event. drop_count +1, saturating at all-ones. The held event is kept.
- Set wins over clear: a spike on c in the same cycle c is granted becomes the new pending[c] with the new timestamp.
- Arbiter: a combinational grant over registered pending.
  - Grant only if fifo_level < FIFO_DEPTH, judged on the registered level; no same-cycle pop credit.
  - Round-robin search starts at last_grant+1 and wraps at NUM_COLS-1 → 0.
  - last_grant is updated only on a grant. Its reset value is NUM_COLS-1, so column 0 has first priority.
- Grant pushes {c, ts_latch[c]} and clears pending[c]. At most one push per cycle.
- FIFO: out_valid = level≠0. Pop on out_valid && out_ready.
- Simultaneous push and pop keeps the level unchanged. Head data is stable while out_valid && !out_ready.
- Reset values: out_valid 0, out_column 0, out_timestamp 0, fifo_level 0, drop_count 0. Pending, pointers and ts are also 0.

## Timing
- Latency from spike to out_valid with the FIFO empty: 2 cycles.
  - Spike in cycle n → pending visible in cycle n+1 → grant in n+1 → FIFO write at edge n+2.
- Throughput: one event per cycle in, one per cycle out.
- Sustained all-column bursts drain at 1/cycle.
- Full FIFO: no grants, pending holds, further spikes on pending columns are dropped.
- Empty FIFO with out_ready=1: no beat is emitted. out_ready is ignored while out_valid=0.
- reset_n low mid-operation clears all state immediately (asynchronously): out_valid falls without waiting for a clock. After release no stale event is emitted.
- Reset release is synchronised by the system; the first capture occurs at the first edge after release.

## Configuration
- SPIKE_READOUT_TIMESTAMP_EN defined: ts counter, ts_latch registers and the timestamp field in the FIFO are present, behaving as above.
- SPIKE_READOUT_TIMESTAMP_EN undefined:
  - The ts counter, ts_latch registers and the timestamp field are removed.
  - The FIFO stores column only. out_timestamp is tied to 0.
  - All other behaviour and latencies are unchanged.

## Test plan
- Reset: hold reset_n low 3 cycles mid-clock → out_valid/out_column/out_timestamp/fifo_level/drop_count all 0 immediately; no beat follows release.
- Single event, NUM_COLS=4, out_ready=1: col_spike[2] pulse at ts=5 → out_valid exactly 2 cycles later for 1 cycle, out_column=2, out_timestamp=5.
- Simultaneous: col_spike=4'b1011 at ts=10, out_ready=1 → three consecutive beats with columns 0, 1, 3, all timestamp 10.
  - A following pulse on columns 0 and 3 grants 0 first, then 3: round-robin order is preserved.
- Backpressure/overflow, FIFO_DEPTH=8, out_ready=0, col_spike[0] every cycle for 12 cycles from ts=0:
  - fifo_level reaches 8 and drop_count=3.
  - Then out_ready=1 → 9 beats with timestamps 0..8, then out_valid=0.
- Wrap, TS_WIDTH=4: spike 17 cycles after reset release → out_timestamp=1.
- Reset mid-drain: 3 entries queued, out_ready=0, pulse reset_n → fifo_level 0 and out_valid 0 without a clock edge; no stale beat after release.
  - With SPIKE_READOUT_TIMESTAMP_EN undefined, re-run the single-event test → out_column=2, out_timestamp=0.
